synthetic_1_sequencer: RTL and testbench

SYNTHETIC_1_SEQUENCER -- requirements
Module: synthetic_1_sequencer

---
 rtl/synthetic_pkg.sv | 55 +++++
 rtl/synthetic_1_sequencer_phase_timer.sv | 30 +++
 rtl/synthetic_1_sequencer.sv | 121 ++++++++++++
 tb/tb_synthetic_1_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synthetic_pkg.sv
// Shared types for the assay sequencer: state encoding, enable-bit positions,
// the result type and a decoder from state to the enable outputs.
package synthetic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    HEAT,
    MIX_A,
    FILT,
    MIX_B,
    DETECT,
    REPORT,
    FAULT
  } state_t;

  // Bit positions inside the 2-bit heater / filter / mixer enable buses.
  localparam int HEAT_DIRECT  = 0;
  localparam int HEAT_POST    = 1;
  localparam int FILT_CHAMBER = 0;
  localparam int FILT_POSTMIX = 1;
  localparam int MIX_FIRST    = 0;
  localparam int MIX_FINAL    = 1;

  typedef logic [7:0] result_t;

  typedef struct packed {
    logic       inlet;
    logic [1:0] heat;
    logic [1:0] filt;
    logic [1:0] mix;
    logic       det;
  } enables_t;

  // Actuator pattern that belongs to a state; everything not listed is off.
  function automatic enables_t state_enables(input state_t s);
    enables_t e;
    e = '0;
    case (s)
      FILL:   e.inlet = 1'b1;
      HEAT: begin
        e.heat[HEAT_DIRECT]  = 1'b1;
        e.heat[HEAT_POST]    = 1'b1;
        e.filt[FILT_CHAMBER] = 1'b1;
      end
      MIX_A:  e.mix[MIX_FIRST]     = 1'b1;
      FILT:   e.filt[FILT_POSTMIX] = 1'b1;
      MIX_B:  e.mix[MIX_FINAL]     = 1'b1;
      DETECT: e.det = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/synthetic_1_sequencer_phase_timer.sv
// Loadable down-counter shared by the timed phases and the detector timeout.
// zero is combinational from the count so the FSM sees expiry in the cycle
// the count reaches zero; the count saturates at zero.
module phase_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] val,
  output logic          zero
);

  logic [TW-1:0] cnt;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/synthetic_1_sequencer.sv
// Assay run sequencer: FILL -> HEAT -> MIX_A -> FILT -> MIX_B -> DETECT ->
// REPORT, with abort, detector timeout (FAULT) and a result handshake.
// Result handshake: res_data is offered while res_valid=1 and is consumed on
// the first cycle with res_valid && res_ready; res_data is stable until then.
// All outputs are registered from the next state, so they change together
// with the state register.
module synthetic_1_sequencer
  import synthetic_pkg::*;
#(
  parameter int FILL_CYC = 16,
  parameter int HEAT_CYC = 64,
  parameter int MIX_CYC  = 32,
  parameter int FILT_CYC = 16,
  parameter int DET_TO   = 255,
  parameter int TW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       det_valid,
  input  logic [7:0] det_data,
  input  logic       res_ready,
  output logic       inlet_en,
  output logic [1:0] heat_en,
  output logic [1:0] filt_en,
  output logic [1:0] mix_en,
  output logic       det_en,
  output logic       busy,
  output logic       res_valid,
  output result_t    res_data,
  output logic       err
);

  // Timer reload values: a phase of N cycles loads N-1; N=0 acts as N=1.
  localparam logic [TW-1:0] FILL_LD = (FILL_CYC > 1) ? TW'(FILL_CYC - 1) : '0;
  localparam logic [TW-1:0] HEAT_LD = (HEAT_CYC > 1) ? TW'(HEAT_CYC - 1) : '0;
  localparam logic [TW-1:0] MIX_LD  = (MIX_CYC  > 1) ? TW'(MIX_CYC  - 1) : '0;
  localparam logic [TW-1:0] FILT_LD = (FILT_CYC > 1) ? TW'(FILT_CYC - 1) : '0;
  localparam logic [TW-1:0] DET_LD  = (DET_TO   > 1) ? TW'(DET_TO   - 1) : '0;

  state_t        state;
  state_t        nxt;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // Next-state decision; abort outranks every other event in active states.
  always_comb begin
    nxt = state;
    if (abort && (state != IDLE) && (state != FAULT)) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) nxt = FILL;
        FILL:    if (tmr_zero) nxt = HEAT;
        HEAT:    if (tmr_zero) nxt = MIX_A;
        MIX_A:   if (tmr_zero) nxt = FILT;
        FILT:    if (tmr_zero) nxt = MIX_B;
        MIX_B:   if (tmr_zero) nxt = DETECT;
        DETECT: begin
          // A strobe in the last timeout cycle still counts as a result.
          if (det_valid)     nxt = REPORT;
          else if (tmr_zero) nxt = FAULT;
        end
        REPORT:  if (res_ready) nxt = IDLE;
        FAULT:   if (start) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Reload the timer on every state change with the length of the new state.
  always_comb begin
    tmr_load = (nxt != state);
    case (nxt)
      FILL:    tmr_val = FILL_LD;
      HEAT:    tmr_val = HEAT_LD;
      MIX_A:   tmr_val = MIX_LD;
      FILT:    tmr_val = FILT_LD;
      MIX_B:   tmr_val = MIX_LD;
      DETECT:  tmr_val = DET_LD;
      default: tmr_val = '0;
    endcase
  end

  phase_timer #(.TW(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (1'b1),
    .val  (tmr_val),
    .zero (tmr_zero)
  );

  // State register with outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      inlet_en  <= 1'b0;
      heat_en   <= 2'b00;
      filt_en   <= 2'b00;
      mix_en    <= 2'b00;
      det_en    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      res_data  <= 8'h00;
    end else begin
      state <= nxt;
      {inlet_en, heat_en, filt_en, mix_en, det_en} <= state_enables(nxt);
      busy      <= (nxt != IDLE) && (nxt != FAULT);
      res_valid <= (nxt == REPORT);
      err       <= (nxt == FAULT);
      if ((state == DETECT) && (nxt == REPORT)) begin
        res_data <= det_data;
      end
    end
  end

endmodule

// File: tb/tb_synthetic_1_sequencer.sv
// Bench for synthetic_1_sequencer: directed scenarios plus random traffic,
// each cycle's expected outputs come from a phase-list model of the assay.
module tb_synthetic_1_sequencer;

  localparam int FILL_CYC = 2;
  localparam int HEAT_CYC = 3;
  localparam int MIX_CYC  = 2;
  localparam int FILT_CYC = 2;
  localparam int DET_TO   = 4;
  localparam int TW       = 16;
  localparam int OW       = 19;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DET   = 2;
  localparam int M_REP   = 3;
  localparam int M_FAULT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       det_valid = 1'b0;
  logic [7:0] det_data = 8'h00;
  logic       res_ready = 1'b0;
  logic       inlet_en;
  logic [1:0] heat_en;
  logic [1:0] filt_en;
  logic [1:0] mix_en;
  logic       det_en;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_data;
  logic       err;

  synthetic_1_sequencer #(
    .FILL_CYC (FILL_CYC),
    .HEAT_CYC (HEAT_CYC),
    .MIX_CYC  (MIX_CYC),
    .FILT_CYC (FILT_CYC),
    .DET_TO   (DET_TO),
    .TW       (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .det_valid (det_valid),
    .det_data  (det_data),
    .res_ready (res_ready),
    .inlet_en  (inlet_en),
    .heat_en   (heat_en),
    .filt_en   (filt_en),
    .mix_en    (mix_en),
    .det_en    (det_en),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err)
  );

  // ---------------- reference model ----------------
  int         m_mode = M_IDLE;
  int         m_ph   = 0;
  int         m_el   = 0;
  int         m_wait = 0;
  logic [7:0] m_res  = 8'h00;

  function automatic int phase_len(input int ph);
    int n;
    case (ph)
      0:       n = FILL_CYC;
      1:       n = HEAT_CYC;
      2:       n = MIX_CYC;
      3:       n = FILT_CYC;
      default: n = MIX_CYC;
    endcase
    return (n < 1) ? 1 : n;
  endfunction

  // Expected {inlet, heat[1:0], filt[1:0], mix[1:0], det, busy, res_valid, err, res_data}.
  function automatic logic [OW-1:0] model_out();
    logic [7:0] en;
    en = 8'h00;
    if (m_mode == M_RUN) begin
      case (m_ph)
        0:       en = 8'b1_00_00_00_0;
        1:       en = 8'b0_11_01_00_0;
        2:       en = 8'b0_00_00_01_0;
        3:       en = 8'b0_00_10_00_0;
        default: en = 8'b0_00_00_10_0;
      endcase
    end else if (m_mode == M_DET) begin
      en = 8'b0_00_00_00_1;
    end
    return {en,
            (m_mode == M_RUN) || (m_mode == M_DET) || (m_mode == M_REP),
            (m_mode == M_REP),
            (m_mode == M_FAULT),
            m_res};
  endfunction

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    int to;
    to = (DET_TO < 1) ? 1 : DET_TO;
    if (rst) begin
      m_mode = M_IDLE; m_ph = 0; m_el = 0; m_wait = 0; m_res = 8'h00;
    end else if (abort && (m_mode == M_RUN || m_mode == M_DET || m_mode == M_REP)) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_RUN; m_ph = 0; m_el = 0; end
        M_RUN: begin
          m_el++;
          if (m_el >= phase_len(m_ph)) begin
            m_ph++;
            m_el = 0;
            if (m_ph == 5) begin m_mode = M_DET; m_wait = 0; end
          end
        end
        M_DET: begin
          if (det_valid) begin
            m_res = det_data;
            m_mode = M_REP;
          end else begin
            m_wait++;
            if (m_wait >= to) m_mode = M_FAULT;
          end
        end
        M_REP:   if (res_ready) m_mode = M_IDLE;
        default: if (start) m_mode = M_IDLE;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(negedge clk) begin : monitor
    logic [OW-1:0] e;
    logic [OW-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {inlet_en, heat_en, filt_en, mix_en, det_en, busy, res_valid, err, res_data};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got=%05h exp=%05h (inlet,heat,filt,mix,det,busy,res_valid,err,res_data)",
                 cyc, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    det_valid = 1'b0; det_data = 8'h00; res_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Step until the model reaches the mode (and phase, if ph >= 0).
  task automatic run_until(input int mode, input int ph, input bit rand_start);
    int n;
    n = 0;
    while (!(m_mode == mode && (ph < 0 || m_ph == ph)) && n < 200) begin
      if (rand_start) start = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    start = 1'b0;
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL reach_mode got=%0d exp=%0d", m_mode, mode);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // reset
    clear_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // nominal run, result 5A on the 2nd DETECT cycle
    pulse_start();
    run_until(M_DET, -1, 1'b0);
    step();
    det_valid = 1'b1; det_data = 8'h5A;
    step();
    det_valid = 1'b0; det_data = 8'h00;
    step(); step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();

    // detector timeout, abort ignored in FAULT, start clears, then normal run
    pulse_start();
    run_until(M_DET, -1, 1'b0);
    repeat (DET_TO) step();
    step();
    abort = 1'b1; step(); abort = 1'b0;
    pulse_start();
    step();
    pulse_start();
    run_until(M_DET, -1, 1'b0);
    det_valid = 1'b1; det_data = 8'($urandom_range(0, 255));
    step();
    det_valid = 1'b0;
    res_ready = 1'b1; step(); res_ready = 1'b0;

    // abort on the 3rd HEAT cycle with stray start pulses
    pulse_start();
    run_until(M_RUN, 1, 1'b1);
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    step();

    // backpressure in REPORT
    pulse_start();
    run_until(M_DET, -1, 1'b1);
    det_valid = 1'b1; det_data = 8'hA3;
    step();
    det_valid = 1'b0; det_data = 8'h00;
    repeat (10) step();
    res_ready = 1'b1; step(); res_ready = 1'b0;
    step();

    // det_valid on the timeout cycle, then abort with res_ready
    pulse_start();
    run_until(M_DET, -1, 1'b0);
    repeat (DET_TO - 1) step();
    det_valid = 1'b1; det_data = 8'($urandom_range(0, 255));
    step();
    det_valid = 1'b0;
    abort = 1'b1; res_ready = 1'b1;
    step();
    clear_inputs();
    step();

    // reset in the middle of MIX_B
    pulse_start();
    run_until(M_RUN, 4, 1'b0);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      abort     = ($urandom_range(0, 99) < 3);
      start     = ($urandom_range(0, 99) < 20);
      det_valid = ($urandom_range(0, 99) < 30);
      det_data  = 8'($urandom_range(0, 255));
      res_ready = ($urandom_range(0, 99) < 40);
      step();
    end
    clear_inputs();
    step();

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending entries", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
